clock_frequency_divider: RTL and testbench

- Divides the system clock down to a low-rate square-wave clock, nominally 10 Hz, from a 50 MHz board clock.
- Used as a slow "tick" clock for user-input sampling, e.g. key-driven cursor movement on the chess layout matrix.
- Pure counter-and-toggle design: one free-running counter and one output flop.
- Also provides a one-cycle pulse, aligned to the input clock, at each output rising edge.

---
 rtl/clock_frequency_divider.sv | 41 ++++
 tb/tb_clock_frequency_divider.sv | 48 ++++
 2 files changed

// File: rtl/clock_frequency_divider.sv
// clock_frequency_divider: divides InClock down to a ~50% duty square wave with a rise-aligned one-cycle tick
module clock_frequency_divider #(
    parameter int INPUT_FREQUENCY  = 50000000,
    parameter int OUTPUT_FREQUENCY = 10
) (
    input  logic InClock,
    input  logic reset,
    output logic OutClock,
    output logic OutRiseTick
);
    localparam int SAFE_OUT    = (OUTPUT_FREQUENCY == 0) ? 1 : OUTPUT_FREQUENCY;
    localparam int RAW_HALF    = INPUT_FREQUENCY / (2 * SAFE_OUT);
    localparam int HALF_PERIOD = (RAW_HALF < 1) ? 1 : RAW_HALF;
    localparam int CNT_WIDTH   = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(HALF_PERIOD - 1);

    if (OUTPUT_FREQUENCY == 0) begin : g_zero_freq
        $fatal(1, "clock_frequency_divider: OUTPUT_FREQUENCY must be non-zero");
    end
    if (OUTPUT_FREQUENCY > INPUT_FREQUENCY / 2) begin : g_too_fast
        $fatal(1, "clock_frequency_divider: OUTPUT_FREQUENCY exceeds INPUT_FREQUENCY/2");
    end

    logic [CNT_WIDTH-1:0] counter;

    // half-period counter; any value at or past the last count wraps to 0 and toggles the output
    always_ff @(posedge InClock) begin
        if (!reset) begin
            counter     <= '0;
            OutClock    <= 1'b0;
            OutRiseTick <= 1'b0;
        end else if (counter >= LAST) begin
            counter     <= '0;
            OutClock    <= ~OutClock;
            OutRiseTick <= ~OutClock;
        end else begin
            counter     <= counter + 1'b1;
            OutRiseTick <= 1'b0;
        end
    end
endmodule

// File: tb/tb_clock_frequency_divider.sv
// tb_clock_frequency_divider: random-reset stimulus against an edge-count model for three divider configurations
module tb_clock_frequency_divider;
    logic       InClock = 1'b0;
    logic [2:0] rst_n;
    logic [2:0] oc;
    logic [2:0] tk;
    int         n [3];
    int         h [3] = '{5, 1, 3};
    int         checks = 0;
    int         failures = 0;

    always #5 InClock = ~InClock;

    clock_frequency_divider #(.INPUT_FREQUENCY(100), .OUTPUT_FREQUENCY(10)) dut_a (
        .InClock(InClock), .reset(rst_n[0]), .OutClock(oc[0]), .OutRiseTick(tk[0]));
    clock_frequency_divider #(.INPUT_FREQUENCY(20), .OUTPUT_FREQUENCY(10)) dut_b (
        .InClock(InClock), .reset(rst_n[1]), .OutClock(oc[1]), .OutRiseTick(tk[1]));
    clock_frequency_divider #(.INPUT_FREQUENCY(100), .OUTPUT_FREQUENCY(15)) dut_c (
        .InClock(InClock), .reset(rst_n[2]), .OutClock(oc[2]), .OutRiseTick(tk[2]));

    task automatic chk(input string tag, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b expected=%b at %0t", tag, got, exp, $time);
        end
    endtask

    initial begin
        rst_n = 3'b000;
        for (int i = 0; i < 3; i++) n[i] = 0;
        for (int c = 0; c < 1200; c++) begin
            for (int i = 0; i < 3; i++)
                rst_n[i] = (c < 3) ? 1'b0 :
                           (c < 213) ? !(i == 0 && c >= 211) :
                           ($urandom_range(39) != 0);
            @(posedge InClock);
            for (int i = 0; i < 3; i++) n[i] = rst_n[i] ? n[i] + 1 : 0;
            #1;
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("outclock%0d_c%0d", i, c), oc[i], ((n[i] / h[i]) % 2) == 1);
                chk($sformatf("risetick%0d_c%0d", i, c), tk[i], n[i] > 0 && (n[i] % (2 * h[i])) == h[i]);
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
